param_tensor_core: RTL and testbench

Parametrised successor to the fixed 4x4 int8 tensor core. Computes C = A x B, or C = C + A x B in accumulate mode, for signed DIM x DIM matrices of DATA_WIDTH elements. It produces LANES output elements per clock and uses a start/busy/done handshake. It sits between the tensor-core register file, which supplies the operands, and the writeback path, which consumes C once done is high.

---
 rtl/param_tensor_core.sv | 142 ++++++++++++++
 tb/tb_param_tensor_core.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_tensor_core.sv
// param_tensor_core: C = A x B (or C += A x B), LANES elements/cycle, done DIM*DIM/LANES edges after start.
// No backpressure: start taken only in IDLE/DONE; TENSOR_CORE_SATURATE_EN selects saturating narrowing over wrap.
module param_tensor_core #(
  parameter int DATA_WIDTH = 8,
  parameter int DIM        = 4,
  parameter int LANES      = 4,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(DIM) + 1
) (
  input  logic                         clock_in,
  input  logic                         reset_n_in,
  input  logic signed [DATA_WIDTH-1:0] tensor_core_input1 [DIM][DIM],
  input  logic signed [DATA_WIDTH-1:0] tensor_core_input2 [DIM][DIM],
  input  logic                         should_start_tensor_core,
  input  logic                         accumulate_mode,
  output logic signed [DATA_WIDTH-1:0] tensor_core_output [DIM][DIM],
  output logic                         is_busy,
  output logic                         is_done_with_calculation
);

  localparam int NUM_EL = DIM * DIM;
  localparam int IDX_W  = $clog2(NUM_EL + 1);
  localparam int RC_W   = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EL - LANES);
  localparam logic [IDX_W-1:0] STEP     = IDX_W'(LANES);

  if ((NUM_EL % LANES) != 0) begin : g_lanes_check
    $error("param_tensor_core: DIM*DIM must be a multiple of LANES");
  end

`ifdef TENSOR_CORE_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
`endif

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [IDX_W-1:0]             r_index;
  logic                         r_acc_mode;
  logic signed [DATA_WIDTH-1:0] r_a [DIM][DIM];
  logic signed [DATA_WIDTH-1:0] r_b [DIM][DIM];
  logic signed [DATA_WIDTH-1:0] r_c [DIM][DIM];

  logic                         w_accept;
  logic                         w_last;
  logic [RC_W-1:0]              w_row [LANES];
  logic [RC_W-1:0]              w_col [LANES];
  logic signed [DATA_WIDTH-1:0] w_res [LANES];

  // Full-width dot product plus optional old C, then narrowed to the element width.
  function automatic logic signed [DATA_WIDTH-1:0] lane_result(
    input logic [RC_W-1:0] row,
    input logic [RC_W-1:0] col
  );
    logic signed [ACC_WIDTH-1:0] sum;
    sum = '0;
    for (int k = 0; k < DIM; k++) begin
      sum = sum + ACC_WIDTH'(r_a[row][k]) * ACC_WIDTH'(r_b[k][col]);
    end
    if (r_acc_mode) begin
      sum = sum + ACC_WIDTH'(r_c[row][col]);
    end
`ifdef TENSOR_CORE_SATURATE_EN
    if (sum > SAT_MAX) begin
      lane_result = SAT_MAX[DATA_WIDTH-1:0];
    end else if (sum < SAT_MIN) begin
      lane_result = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      lane_result = sum[DATA_WIDTH-1:0];
    end
`else
    lane_result = sum[DATA_WIDTH-1:0];
`endif
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (should_start_tensor_core) begin
          w_accept    = 1'b1;
          w_state_nxt = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        w_last = (r_index == LAST_IDX);
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_row[l] = RC_W'((int'(r_index) + l) / DIM);
      w_col[l] = RC_W'((int'(r_index) + l) % DIM);
      w_res[l] = lane_result(w_row[l], w_col[l]);
    end
  end

  // Operands are snapshotted at start so the inputs may change during COMPUTE.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_index    <= '0;
      r_acc_mode <= 1'b0;
      r_a        <= '{default: '0};
      r_b        <= '{default: '0};
      r_c        <= '{default: '0};
    end else if (w_accept) begin
      r_index    <= '0;
      r_acc_mode <= accumulate_mode;
      r_a        <= tensor_core_input1;
      r_b        <= tensor_core_input2;
    end else if (r_state == S_COMPUTE) begin
      r_index <= r_index + STEP;
      for (int l = 0; l < LANES; l++) begin
        r_c[w_row[l]][w_col[l]] <= w_res[l];
      end
    end
  end

  assign tensor_core_output       = r_c;
  assign is_busy                  = (r_state == S_COMPUTE);
  assign is_done_with_calculation = (r_state == S_DONE);

endmodule

// File: tb/tb_param_tensor_core.sv
// Directed bench for param_tensor_core: default 4x4 int8 instance plus an 8x8 int16, 16-lane instance.
module tb_param_tensor_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic signed [7:0]  a [4][4];
  logic signed [7:0]  b [4][4];
  logic signed [7:0]  c [4][4];
  logic start, mode, busy, done;

  logic signed [15:0] a8 [8][8];
  logic signed [15:0] b8 [8][8];
  logic signed [15:0] c8 [8][8];
  logic start8, mode8, busy8, done8;
  longint exp8 [8][8];

  int n_checks = 0;
  int n_fail   = 0;

  param_tensor_core u_dut (
    .clock_in                 (clk),
    .reset_n_in               (rst_n),
    .tensor_core_input1       (a),
    .tensor_core_input2       (b),
    .should_start_tensor_core (start),
    .accumulate_mode          (mode),
    .tensor_core_output       (c),
    .is_busy                  (busy),
    .is_done_with_calculation (done)
  );

  param_tensor_core #(.DATA_WIDTH(16), .DIM(8), .LANES(16)) u_dut8 (
    .clock_in                 (clk),
    .reset_n_in               (rst_n),
    .tensor_core_input1       (a8),
    .tensor_core_input2       (b8),
    .should_start_tensor_core (start8),
    .accumulate_mode          (mode8),
    .tensor_core_output       (c8),
    .is_busy                  (busy8),
    .is_done_with_calculation (done8)
  );

  task automatic chk(input string tag, input longint obs, input longint exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic set_id_ramp();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a[i][j] = (i == j) ? 8'sd1 : 8'sd0;
        b[i][j] = 8'(4*i + j);
      end
  endtask

  task automatic set_fill(input int va, input int vb);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a[i][j] = 8'(va);
        b[i][j] = 8'(vb);
      end
  endtask

  task automatic check_c_ramp(input string tag, input int scale);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk($sformatf("%s[%0d][%0d]", tag, i, j), c[i][j], scale * (4*i + j));
  endtask

  task automatic check_c_fill(input string tag, input int v);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk($sformatf("%s[%0d][%0d]", tag, i, j), c[i][j], v);
  endtask

  // Returns with the accept edge just passed (1 ns after it) and start low again.
  task automatic pulse_start(input logic m);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  function automatic longint narrow16(input longint s);
`ifdef TENSOR_CORE_SATURATE_EN
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
`else
    longint m;
    m = s & 64'hFFFF;
    if (m >= 32768) m = m - 65536;
    return m;
`endif
  endfunction

  task automatic model8(input logic acc);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        longint s;
        s = 0;
        for (int k = 0; k < 8; k++) s = s + longint'(a8[i][k]) * longint'(b8[k][j]);
        if (acc) s = s + exp8[i][j];
        exp8[i][j] = narrow16(s);
      end
  endtask

  task automatic rand_mat8(input logic do_a);
    int v;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        v = int'($urandom_range(0, 511)) - 256;
        if (do_a) a8[i][j] = 16'(v);
        v = int'($urandom_range(0, 511)) - 256;
        b8[i][j] = 16'(v);
      end
  endtask

  task automatic check_c8(input string tag);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        chk($sformatf("%s[%0d][%0d]", tag, i, j), c8[i][j], exp8[i][j]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    mode   = 1'b0;
    start8 = 1'b0;
    mode8  = 1'b0;
    set_id_ramp();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        a8[i][j] = '0;
        b8[i][j] = '0;
      end
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_c33", c[3][3], 0);
    chk("rst_c01", c[0][1], 0);
    chk("rst_busy8", busy8, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Identity times ramp: C == B, row 0 first, four busy cycles
    pulse_start(1'b0);
    chk("t1_busy_c0", busy, 1);
    chk("t1_done_c0", done, 0);
    @(posedge clk); #1;
    for (int j = 0; j < 4; j++) chk($sformatf("t1_row0[%0d]", j), c[0][j], j);
    chk("t1_c11_unwritten", c[1][1], 0);
    chk("t1_busy_c1", busy, 1);
    for (int n = 2; n < 4; n++) begin
      @(posedge clk); #1;
      chk($sformatf("t1_busy_c%0d", n), busy, 1);
      chk($sformatf("t1_done_c%0d", n), done, 0);
    end
    @(posedge clk); #1;
    chk("t1_busy_end", busy, 0);
    chk("t1_done_end", done, 1);
    check_c_ramp("t1_c", 1);

    // Accumulate restart straight from DONE: C = B + I*B
    pulse_start(1'b1);
    chk("t3_done_drop", done, 0);
    chk("t3_busy", busy, 1);
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    chk("t3_done", done, 1);
    chk("t3_c33", c[3][3], 30);
    check_c_ramp("t3_c", 2);

    // Overflow: 4*100*100 = 40000 ; 4*(-128*127) = -65024
    set_fill(100, 100);
    pulse_start(1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("t2a_done", done, 1);
`ifdef TENSOR_CORE_SATURATE_EN
    check_c_fill("t2a_c", 127);
`else
    check_c_fill("t2a_c", 64);
`endif
    set_fill(-128, 127);
    pulse_start(1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("t2b_done", done, 1);
`ifdef TENSOR_CORE_SATURATE_EN
    check_c_fill("t2b_c", -128);
`else
    check_c_fill("t2b_c", 0);
`endif

    // Start during COMPUTE ignored; operand change mid-op has no effect
    set_id_ramp();
    pulse_start(1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) a[i][j] = 8'sd100;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t4_busy_c2", busy, 1);
    @(posedge clk); #1;
    chk("t4_busy_c3", busy, 1);
    @(posedge clk); #1;
    chk("t4_done", done, 1);
    chk("t4_busy_end", busy, 0);
    check_c_ramp("t4_c", 1);

    // Asynchronous reset in the middle of COMPUTE
    set_id_ramp();
    pulse_start(1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_busy_rst", busy, 0);
    chk("t5_done_rst", done, 0);
    chk("t5_c33_rst", c[3][3], 0);
    chk("t5_c01_rst", c[0][1], 0);
    chk("t5_c21_rst", c[2][1], 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_done", done, 0);
    pulse_start(1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("t5_done", done, 1);
    check_c_ramp("t5_c", 1);

    // 8x8 int16 with 16 lanes, then back-to-back accumulate start from DONE
    rand_mat8(1'b1);
    model8(1'b0);
    @(negedge clk);
    start8 = 1'b1;
    mode8  = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("t6_busy_c0", busy8, 1);
    for (int n = 1; n < 4; n++) begin
      @(posedge clk); #1;
      chk($sformatf("t6_busy_c%0d", n), busy8, 1);
    end
    @(posedge clk); #1;
    chk("t6_done", done8, 1);
    chk("t6_busy_end", busy8, 0);
    check_c8("t6_c");
    rand_mat8(1'b0);
    model8(1'b1);
    start8 = 1'b1;
    mode8  = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("t6_restart_busy", busy8, 1);
    chk("t6_restart_done", done8, 0);
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    chk("t6_done2", done8, 1);
    check_c8("t6_acc");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
